column_projector_p: RTL and testbench

Parametrised successor to the fixed 8-column projector. Consumes rows of NUM_COLS packed columns from the column-data FIFO and emits only the flagged columns of matching rows as a COL_W word stream. Groups the output into pages of PAGE_WORDS words and pads the final page with PAD_WORD. Issues one page-complete command per finished page to the command path. Sits between the filter/match stage and the query-data/command FIFOs, with valid/ready on every interface.

---
 rtl/column_projector_p.sv | 217 +++++++++++++++++++++
 tb/tb_column_projector_p.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_projector_p.sv
`default_nettype none
// ============================================================================
// column_projector_p : streams flagged columns of matching rows as padded pages
// Rev 1.0
// ============================================================================
module column_projector_p #(
  parameter int               NUM_COLS   = 8,
  parameter int               COL_W      = 32,
  parameter int               PAGE_WORDS = 1024,
  parameter int               CNT_W      = 32,
  parameter logic [COL_W-1:0] PAD_WORD   = 32'h454E4444
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          record_num,
  input  logic [NUM_COLS-1:0]       column_flag,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] in_data,
  input  logic                      in_match,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL_W-1:0]          out_data,
  output logic                      out_last,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [63:0]               cmd_data
);

  localparam int                c_PW_W     = $clog2(PAGE_WORDS + 1);
  localparam logic [c_PW_W-1:0] c_LAST_POS = c_PW_W'(PAGE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW_WAIT = 3'd1,
    S_PROJECT  = 3'd2,
    S_PAD      = 3'd3,
    S_CMD      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNT_W-1:0]           r_rec_num;
  logic [CNT_W-1:0]           r_row_cnt;
  logic [NUM_COLS-1:0]        r_flag;
  logic [NUM_COLS-1:0]        r_rem_mask;
  logic [NUM_COLS*COL_W-1:0]  r_row;
  logic                       r_last_row;
  logic [c_PW_W-1:0]          r_page_words;
  logic [c_PW_W-1:0]          r_valid_words;
  logic [31:0]                r_page_idx;

  logic [NUM_COLS-1:0]        w_low_bit;
  logic [NUM_COLS-1:0]        w_rem_after;
  logic [COL_W-1:0]           w_proj_word;
  logic                       w_last_now;
  logic                       w_page_full;
  logic [31:0]                w_valid_ext;

  // Isolate the lowest pending column as a one-hot so selection and clearing share it.
  assign w_low_bit   = r_rem_mask & (~r_rem_mask + NUM_COLS'(1));
  assign w_rem_after = r_rem_mask & ~w_low_bit;
  assign w_last_now  = (r_row_cnt == r_rec_num - CNT_W'(1));
  assign w_page_full = (r_page_words == c_LAST_POS);
  assign w_valid_ext = 32'(r_valid_words);

  always_comb begin
    w_proj_word = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (w_low_bit[i]) begin
        w_proj_word = r_row[i*COL_W +: COL_W];
      end
    end
  end

  assign out_data = (r_state == S_PROJECT) ? w_proj_word :
                    (r_state == S_PAD)     ? PAD_WORD    : '0;
  assign out_last = ((r_state == S_PROJECT) || (r_state == S_PAD)) && w_page_full;
  assign cmd_data = {r_page_idx, w_valid_ext};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cmd_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = ((record_num == '0) || (column_flag == '0)) ? S_DONE : S_ROW_WAIT;
        end
      end
      S_ROW_WAIT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_match) begin
            w_state_nxt = S_PROJECT;
          end else if (w_last_now) begin
            w_state_nxt = (r_page_words != '0) ? S_PAD : S_DONE;
          end
        end
      end
      S_PROJECT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (w_page_full) begin
            w_state_nxt = S_CMD;
          end else if (w_rem_after == '0) begin
            // The word just sent leaves a partial page, so job end always pads.
            w_state_nxt = r_last_row ? S_PAD : S_ROW_WAIT;
          end
        end
      end
      S_PAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && w_page_full) begin
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          if (r_rem_mask != '0) begin
            w_state_nxt = S_PROJECT;
          end else if (r_last_row) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ROW_WAIT;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rec_num     <= '0;
      r_row_cnt     <= '0;
      r_flag        <= '0;
      r_rem_mask    <= '0;
      r_row         <= '0;
      r_last_row    <= 1'b0;
      r_page_words  <= '0;
      r_valid_words <= '0;
      r_page_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rec_num     <= record_num;
            r_flag        <= column_flag;
            r_row_cnt     <= '0;
            r_last_row    <= 1'b0;
            r_rem_mask    <= '0;
            r_page_words  <= '0;
            r_valid_words <= '0;
            r_page_idx    <= '0;
          end
        end
        S_ROW_WAIT: begin
          if (in_valid) begin
            r_row_cnt  <= r_row_cnt + CNT_W'(1);
            r_last_row <= w_last_now;
            if (in_match) begin
              r_row      <= in_data;
              r_rem_mask <= r_flag;
            end
          end
        end
        S_PROJECT: begin
          if (out_ready) begin
            r_rem_mask    <= w_rem_after;
            r_page_words  <= r_page_words + c_PW_W'(1);
            r_valid_words <= r_valid_words + c_PW_W'(1);
          end
        end
        S_PAD: begin
          if (out_ready) begin
            r_page_words <= r_page_words + c_PW_W'(1);
          end
        end
        S_CMD: begin
          if (cmd_ready) begin
            r_page_idx    <= r_page_idx + 32'd1;
            r_page_words  <= '0;
            r_valid_words <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_column_projector_p.sv
`default_nettype none
// ============================================================================
// tb_column_projector_p : scoreboard bench for column_projector_p
// Rev 1.0
// ============================================================================
module tb_column_projector_p;

  localparam logic [31:0] c_PAD = 32'h454E4444;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  record_num = '0;
  logic [7:0]   column_flag = '0;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = '0;
  logic         in_match = 1'b0;
  logic         out_ready = 1'b1;
  logic         cmd_ready = 1'b1;
  logic         sel = 1'b0;
  bit           rand_mode = 1'b0;

  always #5 clk = ~clk;

  wire a_busy, a_done, a_in_ready, a_out_valid, a_out_last, a_cmd_valid;
  wire b_busy, b_done, b_in_ready, b_out_valid, b_out_last, b_cmd_valid;
  wire [31:0] a_out_data, b_out_data;
  wire [63:0] a_cmd_data, b_cmd_data;
  wire w_start_a = start & ~sel;
  wire w_start_b = start & sel;

  column_projector_p u_dut_big (
    .clk(clk), .rst(rst), .start(w_start_a), .record_num(record_num),
    .column_flag(column_flag), .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_match(in_match),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .cmd_valid(a_cmd_valid), .cmd_ready(cmd_ready), .cmd_data(a_cmd_data)
  );

  column_projector_p #(.PAGE_WORDS(4)) u_dut_small (
    .clk(clk), .rst(rst), .start(w_start_b), .record_num(record_num),
    .column_flag(column_flag), .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_match(in_match),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .cmd_valid(b_cmd_valid), .cmd_ready(cmd_ready), .cmd_data(b_cmd_data)
  );

  wire        w_busy      = sel ? b_busy      : a_busy;
  wire        w_done      = sel ? b_done      : a_done;
  wire        w_in_ready  = sel ? b_in_ready  : a_in_ready;
  wire        w_out_valid = sel ? b_out_valid : a_out_valid;
  wire        w_out_last  = sel ? b_out_last  : a_out_last;
  wire        w_cmd_valid = sel ? b_cmd_valid : a_cmd_valid;
  wire [31:0] w_out_data  = sel ? b_out_data  : a_out_data;
  wire [63:0] w_cmd_data  = sel ? b_cmd_data  : a_cmd_data;

  int n_chk = 0;
  int n_bad = 0;
  int obs_words = 0, obs_cmds = 0, n_exp_words = 0, n_exp_cmds = 0;
  bit mon_en = 1'b0;
  logic [32:0]  exp_words[$];
  logic [63:0]  exp_cmds[$];
  logic [255:0] rows[16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops on each transfer and checks hold stability while stalled.
  logic        stall_o = 1'b0, stall_c = 1'b0, held_l = 1'b0;
  logic [31:0] held_d = '0;
  logic [63:0] held_c = '0;
  logic [32:0] e_w;
  logic [63:0] e_c;
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_o) begin
        check("hold_valid", 64'(w_out_valid), 64'(1));
        check("hold_data", 64'(w_out_data), 64'(held_d));
        check("hold_last", 64'(w_out_last), 64'(held_l));
      end
      if (w_out_valid && out_ready) begin
        obs_words++;
        if (exp_words.size() > 0) begin
          e_w = exp_words.pop_front();
          check("out_data", 64'(w_out_data), 64'(e_w[31:0]));
          check("out_last", 64'(w_out_last), 64'(e_w[32]));
        end
      end
      stall_o = w_out_valid && !out_ready;
      held_d  = w_out_data;
      held_l  = w_out_last;
      if (stall_c) begin
        check("hold_cmd_valid", 64'(w_cmd_valid), 64'(1));
        check("hold_cmd_data", w_cmd_data, held_c);
      end
      if (w_cmd_valid && cmd_ready) begin
        obs_cmds++;
        if (exp_cmds.size() > 0) begin
          e_c = exp_cmds.pop_front();
          check("cmd_data", w_cmd_data, e_c);
        end
      end
      stall_c = w_cmd_valid && !cmd_ready;
      held_c  = w_cmd_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 99) < 30);
        cmd_ready = ($urandom_range(0, 99) < 30);
      end else begin
        out_ready = 1'b1;
        cmd_ready = 1'b1;
      end
    end
  end

  task automatic fill_rows(input bit rnd);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++)
        rows[r][c*32 +: 32] = rnd ? 32'($urandom) : 32'(16 * r + c);
  endtask

  task automatic build_model(input bit s, input logic [7:0] flag, input int nrows, input logic [15:0] m);
    int pw, cnt, vcnt, pidx;
    pw = s ? 4 : 1024;
    cnt = 0; vcnt = 0; pidx = 0;
    if (flag != 8'h00 && nrows != 0) begin
      for (int r = 0; r < nrows; r++) begin
        if (m[r]) begin
          for (int c = 0; c < 8; c++) begin
            if (flag[c]) begin
              exp_words.push_back({(cnt == pw - 1), rows[r][c*32 +: 32]});
              n_exp_words++;
              cnt++; vcnt++;
              if (cnt == pw) begin
                exp_cmds.push_back({32'(pidx), 32'(vcnt)});
                n_exp_cmds++;
                pidx++; cnt = 0; vcnt = 0;
              end
            end
          end
        end
      end
      if (cnt != 0) begin
        while (cnt < pw) begin
          exp_words.push_back({(cnt == pw - 1), c_PAD});
          n_exp_words++;
          cnt++;
        end
        exp_cmds.push_back({32'(pidx), 32'(vcnt)});
        n_exp_cmds++;
      end
    end
  endtask

  task automatic do_start(input bit s, input int nrows, input logic [7:0] flag);
    obs_words = 0; obs_cmds = 0;
    sel = s;
    record_num = 32'(nrows);
    column_flag = flag;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_row(input int r, input bit m);
    int  g;
    int  guard;
    bit  acc;
    if (rand_mode) begin
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_data = rows[r]; in_match = m;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 20000) begin
      @(negedge clk);
      if (w_in_ready) acc = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; in_match = 1'b0;
    check("row_accept", 64'(acc), 64'(1));
  endtask

  task automatic wait_done();
    int lat;
    bit seen;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20000) begin
      if (w_done) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    check("done_seen", 64'(seen), 64'(1));
    if (n_exp_words == 0) check("done_lat", 64'(lat), 64'(0));
    check("busy_at_done", 64'(w_busy), 64'(0));
    @(negedge clk);
    check("done_pulse", 64'(w_done), 64'(0));
    check("words_left", 64'(exp_words.size()), 64'(0));
    check("word_cnt", 64'(obs_words), 64'(n_exp_words));
    check("cmds_left", 64'(exp_cmds.size()), 64'(0));
    check("cmd_cnt", 64'(obs_cmds), 64'(n_exp_cmds));
    @(posedge clk); #1;
  endtask

  task automatic run_job(input bit s, input logic [7:0] flag, input int nrows,
                         input logic [15:0] m, input bit rnd);
    bit trivial;
    trivial = (flag == 8'h00) || (nrows == 0);
    fill_rows(rnd);
    n_exp_words = 0; n_exp_cmds = 0;
    build_model(s, flag, nrows, m);
    do_start(s, nrows, flag);
    @(negedge clk);
    check("busy_start", 64'(w_busy), 64'(!trivial));
    if (!trivial) begin
      @(posedge clk); #1;
      for (int r = 0; r < nrows; r++) send_row(r, m[r]);
      @(negedge clk);
    end
    wait_done();
  endtask

  initial begin
    int guard;
    logic [7:0] rf;
    logic [15:0] rm;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(w_busy), 64'(0));
    check("rst_in_ready", 64'(w_in_ready), 64'(0));
    check("rst_out_valid", 64'(w_out_valid), 64'(0));
    check("rst_cmd_valid", 64'(w_cmd_valid), 64'(0));
    check("rst_out_data", 64'(w_out_data), 64'(0));
    check("rst_cmd_data", w_cmd_data, 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_job(1'b0, 8'b1000_0101, 2, 16'b11, 1'b0);
    run_job(1'b0, 8'h01, 4, 16'b0101, 1'b0);
    run_job(1'b1, 8'hFF, 1, 16'b1, 1'b0);
    run_job(1'b0, 8'hFF, 3, 16'b0, 1'b0);
    run_job(1'b0, 8'h00, 2, 16'b11, 1'b0);
    run_job(1'b1, 8'hFF, 0, 16'b0, 1'b0);

    rand_mode = 1'b1;
    rf = 8'($urandom_range(1, 255));
    rm = 16'($urandom);
    run_job(1'b1, rf, 6, rm, 1'b1);
    run_job(1'b1, 8'b0111_0110, 3, 16'b111, 1'b1);
    run_job(1'b0, 8'hFF, 2, 16'b10, 1'b1);
    rand_mode = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a page, then a clean job must restart at page 0.
    fill_rows(1'b0);
    n_exp_words = 0; n_exp_cmds = 0;
    build_model(1'b0, 8'hFF, 1, 16'b1);
    do_start(1'b0, 1, 8'hFF);
    send_row(0, 1'b1);
    guard = 0;
    @(negedge clk);
    while (!w_out_valid && guard < 100) begin @(negedge clk); guard++; end
    check("proj_reached", 64'(w_out_valid), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 64'(w_busy), 64'(0));
    check("mid_rst_done", 64'(w_done), 64'(0));
    check("mid_rst_in_ready", 64'(w_in_ready), 64'(0));
    check("mid_rst_out_valid", 64'(w_out_valid), 64'(0));
    check("mid_rst_out_last", 64'(w_out_last), 64'(0));
    check("mid_rst_cmd_valid", 64'(w_cmd_valid), 64'(0));
    check("mid_rst_out_data", 64'(w_out_data), 64'(0));
    check("mid_rst_cmd_data", w_cmd_data, 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_words.delete();
    exp_cmds.delete();
    stall_o = 1'b0; stall_c = 1'b0;
    mon_en = 1'b1;
    run_job(1'b0, 8'h01, 1, 16'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
